// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch controller.
//   DATA_W / ADDR_W / DEPTH : instruction memory geometry
//   LEN_W                   : width of a program length (0..DEPTH)
//   state_t                 : controller state encoding
//   mem_req_t               : registered memory-side request (strobes, pointer, data)
package cpu_pkg;
  localparam int DATA_W = 26;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 10;
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, WAIT, HOLD, DONE} state_t;

  typedef struct packed {
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] pointer;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch controller.
//   pc_clr       : force pc to 0 (start of run)
//   pc_load      : take next_pc (accepted handshake that continues the run)
//   jump_valid/jump_addr : redirect for the current handshake
//   prog_len     : number of loaded words
//   next_pc      : jump target or pc+1
//   out_of_range : next_pc >= prog_len (program ends)
//   jump_err     : jump requested to a target >= prog_len
module fetch_pc
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_clr,
  input  logic              pc_load,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [LEN_W-1:0]  prog_len,
  output logic [ADDR_W-1:0] next_pc,
  output logic              out_of_range,
  output logic              jump_err
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LEN_W-1:0]  next_ext;

  // Compare at LEN_W so pc+1 at the last word cannot wrap below prog_len.
  always_comb begin
    next_ext     = jump_valid ? LEN_W'(jump_addr) : LEN_W'(pc_q) + LEN_W'(1);
    jump_err     = jump_valid && (LEN_W'(jump_addr) >= prog_len);
    out_of_range = next_ext >= prog_len;
    next_pc      = next_ext[ADDR_W-1:0];
    pc_d         = pc_q;
    if (pc_clr)       pc_d = '0;
    else if (pc_load) pc_d = next_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: loads a program into the instruction memory
// and then fetches it (sequentially or via jumps) to the decoder.
//   clk, reset                    : clock, async active-high reset
//   load_req/load_valid/load_last/load_data : loader stream
//   run                           : start / keep running (level)
//   jump_valid/jump_addr          : redirect, sampled on decoder handshake
//   instr/instr_valid/instr_ready : decoder handshake
//   busy/done/addr_err            : status (addr_err sticky until reset)
//   mem_pointer/mem_write/mem_read/mem_wdata/mem_rdata : memory port
module instr_fetch_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  input  logic              run,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mem_pointer,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic [LEN_W-1:0]  prog_len_q, prog_len_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  mem_req_t          mem_q, mem_d;

  logic              pc_clr, pc_load;
  logic [ADDR_W-1:0] next_pc;
  logic              out_of_range, jump_err;

  fetch_pc u_pc (
    .clk          (clk),
    .rst          (reset),
    .pc_clr       (pc_clr),
    .pc_load      (pc_load),
    .jump_valid   (jump_valid),
    .jump_addr    (jump_addr),
    .prog_len     (prog_len_q),
    .next_pc      (next_pc),
    .out_of_range (out_of_range),
    .jump_err     (jump_err)
  );

  always_comb begin
    state_d       = state_q;
    ld_ptr_d      = ld_ptr_q;
    prog_len_d    = prog_len_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    addr_err_d    = addr_err_q;
    mem_d         = mem_q;
    mem_d.write   = 1'b0;  // strobes are single-cycle pulses
    mem_d.read    = 1'b0;
    pc_clr        = 1'b0;
    pc_load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d  = LOAD;
          ld_ptr_d = '0;
        end else if (run) begin
          if (prog_len_q == '0) begin
            state_d = DONE;
          end else begin
            state_d       = FETCH;
            pc_clr        = 1'b1;
            mem_d.read    = 1'b1;
            mem_d.pointer = '0;
          end
        end
      end
      LOAD: begin
        if (load_valid) begin
          mem_d.write   = 1'b1;
          mem_d.pointer = ld_ptr_q;
          mem_d.wdata   = load_data;
          ld_ptr_d      = ld_ptr_q + ADDR_W'(1);
          // Leaving on the last physical word means a later load_valid can
          // never reach the memory, so the pointer never wraps.
          if (load_last || ld_ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d    = IDLE;
            prog_len_d = LEN_W'(ld_ptr_q) + LEN_W'(1);
          end
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        instr_d       = mem_rdata;
        instr_valid_d = 1'b1;
        state_d       = HOLD;
      end
      HOLD: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (jump_err) begin
            addr_err_d = 1'b1;
            state_d    = DONE;
          end else if (out_of_range) begin
            state_d = DONE;
          end else begin
            pc_load       = 1'b1;
            state_d       = FETCH;
            mem_d.read    = 1'b1;
            mem_d.pointer = next_pc;
          end
        end
      end
      DONE: if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ld_ptr_q      <= '0;
      prog_len_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_q         <= '0;
    end else begin
      state_q       <= state_d;
      ld_ptr_q      <= ld_ptr_d;
      prog_len_q    <= prog_len_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_q         <= mem_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign addr_err    = addr_err_q;
  assign mem_pointer = mem_q.pointer;
  assign mem_write   = mem_q.write;
  assign mem_read    = mem_q.read;
  assign mem_wdata   = mem_q.wdata;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: a behavioural memory, a program
// walk model (list of expected fetches) and randomized ready/jump stimulus.
module tb_instr_fetch_ctrl;
  localparam int DW = 26;
  localparam int AW = 4;

  logic          clk = 0, reset = 1;
  logic          load_req = 0, load_valid = 0, load_last = 0, run = 0;
  logic [DW-1:0] load_data = '0;
  logic          jump_valid = 0, instr_ready = 0;
  logic [AW-1:0] jump_addr = '0;
  logic [DW-1:0] instr, mem_wdata, mem_rdata = '0;
  logic          instr_valid, busy, done, addr_err, mem_write, mem_read;
  logic [AW-1:0] mem_pointer;

  instr_fetch_ctrl dut (
    .clk(clk), .reset(reset), .load_req(load_req), .load_valid(load_valid),
    .load_last(load_last), .load_data(load_data), .run(run),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy),
    .done(done), .addr_err(addr_err), .mem_pointer(mem_pointer),
    .mem_write(mem_write), .mem_read(mem_read), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0, overlap = 0, stall_bad = 0;
  bit timed_out;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] prog [16];
  int  plen;
  int  jplan [16];
  bit  exp_err;
  int  wr_ptr[$], rd_log[$], hs_cyc[$], exp_rd[$];
  logic [DW-1:0] wr_dat[$], hs_log[$], exp_instr[$];

  // Memory with one-cycle read latency, plus observation logs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) begin mem[mem_pointer] <= mem_wdata; wr_ptr.push_back(int'(mem_pointer)); wr_dat.push_back(mem_wdata); end
    if (mem_read)  begin mem_rdata <= mem[mem_pointer]; rd_log.push_back(int'(mem_pointer)); end
    if (mem_write && mem_read) overlap <= overlap + 1;
    if (instr_valid && instr_ready) begin hs_log.push_back(instr); hs_cyc.push_back(cyc); end
  end

  // Expected fetch order: walk the program, following planned jumps.
  task automatic model_run();
    int pc, k, nxt;
    exp_instr.delete(); exp_rd.delete(); exp_err = 0;
    if (plen == 0) return;
    pc = 0; k = 0;
    forever begin
      exp_rd.push_back(pc); exp_instr.push_back(prog[pc]);
      if (k < 16 && jplan[k] >= 0) begin
        if (jplan[k] >= plen) begin exp_err = 1; break; end
        nxt = jplan[k];
      end else nxt = pc + 1;
      k++;
      if (nxt >= plen) break;
      pc = nxt;
    end
  endtask

  task automatic load_prog(input int n, input bit use_last, input bit gaps);
    wr_ptr.delete(); wr_dat.delete();
    @(negedge clk); load_req = 1;
    @(negedge clk); load_req = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin load_valid = 0; load_data = DW'($urandom); repeat ($urandom_range(0, 2)) @(negedge clk); end
      load_valid = 1; load_data = prog[i]; load_last = use_last && (i == n - 1);
      @(negedge clk);
    end
    load_valid = 0; load_last = 0;
    repeat (2) @(negedge clk);
  endtask

  // mode 0: always ready; 1: random ready; 2: stall 5 cycles on first instr.
  task automatic drive_run(input int mode);
    int k, stall; bit pend, ok, rdy; logic [DW-1:0] prev;
    hs_log.delete(); hs_cyc.delete(); rd_log.delete();
    stall_bad = 0; k = 0; stall = 0; pend = 0; ok = 0; prev = '0;
    @(negedge clk); run = 1; t0 = cyc;
    for (int b = 0; b < 500; b++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1; break; end
      if (pend && (instr_valid !== 1'b1 || instr !== prev)) stall_bad++;
      if (instr_valid === 1'b1 && mem_read !== 1'b0) stall_bad++;
      case (mode)
        0: rdy = 1;
        1: rdy = ($urandom_range(0, 2) != 0);
        default: rdy = !(k == 0 && stall < 5);
      endcase
      if (mode == 2 && k == 0 && instr_valid === 1'b1 && !rdy) stall++;
      instr_ready = rdy;
      if (instr_valid === 1'b1 && rdy) begin
        jump_valid = (k < 16) && (jplan[k] >= 0);
        jump_addr  = jump_valid ? AW'(jplan[k]) : AW'($urandom_range(0, 15));
        k++; pend = 0;
      end else begin
        // Noise on the jump lines: must be ignored without a handshake.
        jump_valid = 1'($urandom_range(0, 1)); jump_addr = AW'($urandom_range(0, 15));
        pend = (instr_valid === 1'b1); prev = instr;
      end
    end
    timed_out = !ok; instr_ready = 0; jump_valid = 0;
  endtask

  task automatic end_run();
    run = 0; repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if ({instr, instr_valid, busy, done, addr_err, mem_pointer, mem_write, mem_read, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got instr=%h v=%b busy=%b done=%b err=%b ptr=%0d w=%b r=%b, want all 0",
                         instr, instr_valid, busy, done, addr_err, mem_pointer, mem_write, mem_read); end
    @(negedge clk); reset = 0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy=%b want 0", busy); end
  endtask

  task automatic test_basic();
    prog[0] = 26'h0000001; prog[1] = 26'h0000002; prog[2] = 26'h0000003;
    plen = 3; foreach (jplan[i]) jplan[i] = -1;
    load_prog(3, 1, 0);
    n_chk++; if (wr_ptr.size() !== 3) begin n_fail++; $display("FAIL basic_wr_count got %0d want 3", wr_ptr.size()); end
    for (int i = 0; i < 3 && i < wr_ptr.size(); i++) begin
      n_chk++; if (wr_ptr[i] !== i || wr_dat[i] !== prog[i]) begin n_fail++;
        $display("FAIL basic_wr[%0d] got ptr=%0d data=%h want ptr=%0d data=%h", i, wr_ptr[i], wr_dat[i], i, prog[i]); end
    end
    model_run(); drive_run(0);
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout done never rose"); end
    n_chk++; if (hs_log.size() !== exp_instr.size()) begin n_fail++; $display("FAIL basic_hs_count got %0d want %0d", hs_log.size(), exp_instr.size()); end
    for (int i = 0; i < exp_instr.size() && i < hs_log.size(); i++) begin
      n_chk++; if (hs_log[i] !== exp_instr[i]) begin n_fail++; $display("FAIL basic_instr[%0d] got %h want %h", i, hs_log[i], exp_instr[i]); end
      n_chk++; if (hs_cyc[i] !== t0 + 3 + 3 * i) begin n_fail++; $display("FAIL basic_timing[%0d] got cycle %0d want %0d", i, hs_cyc[i] - t0, 3 + 3 * i); end
    end
    n_chk++; if (rd_log != exp_rd) begin n_fail++; $display("FAIL basic_reads got %p want %p", rd_log, exp_rd); end
    n_chk++; if (done !== 1'b1 || addr_err !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%b err=%b want 1 0", done, addr_err); end
    end_run();
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL basic_idle got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_full_load();
    for (int i = 0; i < 11; i++) prog[i] = DW'($urandom);
    plen = 10; foreach (jplan[i]) jplan[i] = -1;
    load_prog(11, 0, 0);  // the 11th word arrives after LOAD has been left
    n_chk++; if (wr_ptr.size() !== 10) begin n_fail++; $display("FAIL full_wr_count got %0d want 10", wr_ptr.size()); end
    for (int i = 0; i < 10 && i < wr_ptr.size(); i++) begin
      n_chk++; if (wr_ptr[i] !== i || wr_dat[i] !== prog[i]) begin n_fail++;
        $display("FAIL full_wr[%0d] got ptr=%0d data=%h want ptr=%0d data=%h", i, wr_ptr[i], wr_dat[i], i, prog[i]); end
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_idle busy=%b want 0", busy); end
    model_run(); drive_run(1);
    n_chk++; if (timed_out || hs_log != exp_instr) begin n_fail++; $display("FAIL full_run got %0d instrs want %0d (timeout=%b)", hs_log.size(), exp_instr.size(), timed_out); end
    n_chk++; if (stall_bad !== 0) begin n_fail++; $display("FAIL full_stable got %0d violations want 0", stall_bad); end
    end_run();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) prog[i] = DW'($urandom);
    plen = 4; foreach (jplan[i]) jplan[i] = -1;
    load_prog(4, 1, 1);
    model_run(); drive_run(2);
    n_chk++; if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_stable got %0d violations want 0", stall_bad); end
    n_chk++; if (hs_cyc.size() < 2 || hs_cyc[0] !== t0 + 8) begin n_fail++; $display("FAIL stall_hs_cycle got %0d want 8", hs_cyc.size() ? hs_cyc[0] - t0 : -1); end
    n_chk++; if (timed_out || hs_log != exp_instr || rd_log != exp_rd) begin n_fail++; $display("FAIL stall_seq got %0d instrs reads %p want %0d reads %p", hs_log.size(), rd_log, exp_instr.size(), exp_rd); end
    end_run();
  endtask

  task automatic test_jump();
    for (int i = 0; i < 4; i++) prog[i] = DW'($urandom);
    plen = 4; foreach (jplan[i]) jplan[i] = -1; jplan[0] = 2;
    load_prog(4, 1, 0);
    model_run(); drive_run(0);
    n_chk++; if (rd_log.size() !== 3 || rd_log[0] !== 0 || rd_log[1] !== 2 || rd_log[2] !== 3) begin n_fail++; $display("FAIL jump_order got %p want 0 2 3", rd_log); end
    n_chk++; if (timed_out || hs_log != exp_instr || done !== 1'b1 || addr_err !== 1'b0) begin n_fail++; $display("FAIL jump_done got n=%0d done=%b err=%b want n=3 done=1 err=0", hs_log.size(), done, addr_err); end
    end_run();
  endtask

  task automatic test_random_jumps();
    for (int r = 0; r < 4; r++) begin
      plen = $urandom_range(1, 10);
      for (int i = 0; i < plen; i++) prog[i] = DW'($urandom);
      foreach (jplan[i]) jplan[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, plen - 1)) : -1;
      load_prog(plen, 1, 1);
      model_run(); drive_run(1);
      n_chk++; if (timed_out || hs_log != exp_instr || rd_log != exp_rd) begin n_fail++;
        $display("FAIL rjump[%0d] got reads %p want %p (timeout=%b)", r, rd_log, exp_rd, timed_out); end
      n_chk++; if (stall_bad !== 0 || overlap !== 0 || addr_err !== 1'b0) begin n_fail++;
        $display("FAIL rjump_hold[%0d] got stall=%0d overlap=%0d err=%b want 0 0 0", r, stall_bad, overlap, addr_err); end
      end_run();
    end
  endtask

  task automatic test_jump_err();
    for (int i = 0; i < 4; i++) prog[i] = DW'($urandom);
    plen = 4; foreach (jplan[i]) jplan[i] = -1; jplan[0] = 7;
    load_prog(4, 1, 0);
    model_run(); drive_run(0);
    n_chk++; if (timed_out || addr_err !== exp_err || done !== 1'b1 || hs_log.size() !== 1) begin n_fail++;
      $display("FAIL jump_err got err=%b done=%b n=%0d want err=%b done=1 n=1", addr_err, done, hs_log.size(), exp_err); end
    end_run();
    n_chk++; if (addr_err !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL err_sticky got err=%b done=%b want 1 0", addr_err, done); end
  endtask

  task automatic test_reset_wait();
    bit seen;
    for (int i = 0; i < 3; i++) prog[i] = DW'($urandom);
    load_prog(3, 1, 0);
    @(negedge clk); run = 1; seen = 0;
    for (int b = 0; b < 10; b++) begin @(negedge clk); if (mem_read === 1'b1) begin seen = 1; break; end end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL rstwait_fetch got no mem_read want one"); end
    @(negedge clk);  // WAIT cycle
    #2 reset = 1; #1;
    n_chk++; if ({instr, instr_valid, busy, done, addr_err, mem_pointer, mem_write, mem_read, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL rstwait_outputs got v=%b busy=%b done=%b err=%b r=%b want all 0", instr_valid, busy, done, addr_err, mem_read); end
    @(negedge clk); rd_log.delete(); reset = 0;
    @(negedge clk);
    n_chk++; if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstwait_done got done=%b busy=%b want 1 1", done, busy); end
    repeat (2) @(negedge clk);
    n_chk++; if (rd_log.size() !== 0) begin n_fail++; $display("FAIL rstwait_noread got %0d reads want 0", rd_log.size()); end
    end_run();
  endtask

  task automatic test_load_run_same();
    rd_log.delete();
    @(negedge clk); load_req = 1; run = 1;
    @(negedge clk); load_req = 0; run = 0;
    n_chk++; if (busy !== 1'b1 || mem_read !== 1'b0 || done !== 1'b0) begin n_fail++;
      $display("FAIL same_cycle got busy=%b read=%b done=%b want 1 0 0", busy, mem_read, done); end
    load_valid = 1; load_last = 1; load_data = DW'($urandom);
    @(negedge clk); load_valid = 0; load_last = 0;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || rd_log.size() !== 0) begin n_fail++; $display("FAIL same_exit got busy=%b reads=%0d want 0 0", busy, rd_log.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_load();
    test_stall();
    test_jump();
    test_random_jumps();
    test_jump_err();
    test_reset_wait();
    test_load_run_same();
    n_chk++; if (overlap !== 0) begin n_fail++; $display("FAIL strobe_overlap got %0d cycles want 0", overlap); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
